// File: rtl/bomb_ctrl_if.sv
// Bomb controller bus: player-side requests and position in, bomb status,
// lethal tile set and map-clear strobe out.
//   master : player/map side (drives frame_tick, bomb_drop, userX, userY)
//   slave  : bomb_ctrl (drives bombX/Y, bomb_active, blast_active,
//            die_addr, ram_addr, ram_en)
interface bomb_ctrl_if;
    logic             frame_tick;
    logic             bomb_drop;
    logic [9:0]       userX;
    logic [9:0]       userY;
    logic [9:0]       bombX;
    logic [9:0]       bombY;
    logic             bomb_active;
    logic             blast_active;
    logic [4:0][9:0]  die_addr;     // [0] centre, [1] left, [2] right, [3] up, [4] down
    logic [9:0]       ram_addr;
    logic             ram_en;

    modport master (
        output frame_tick, bomb_drop, userX, userY,
        input  bombX, bombY, bomb_active, blast_active, die_addr, ram_addr, ram_en
    );

    modport slave (
        input  frame_tick, bomb_drop, userX, userY,
        output bombX, bombY, bomb_active, blast_active, die_addr, ram_addr, ram_en
    );
endinterface

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: single-bomb lifecycle for a 20x15 tile map.
// Drop snaps the player sprite centre to a tile, a fuse counts frame ticks,
// the blast exposes the centre plus four neighbours as lethal tiles, then the
// map entries of those tiles are cleared one per cycle.
// Ports:
//   Clk   - system clock (rising edge)
//   Reset - asynchronous, active-high
//   bus   - bomb_ctrl_if.slave (inputs frame_tick, bomb_drop, userX, userY;
//           outputs bombX, bombY, bomb_active, blast_active, die_addr,
//           ram_addr, ram_en). All outputs come straight from flops.
module bomb_ctrl #(
    parameter logic [7:0] FUSE_FRAMES  = 8'd120,
    parameter logic [7:0] BLAST_FRAMES = 8'd30
) (
    input  logic        Clk,
    input  logic        Reset,
    bomb_ctrl_if.slave  bus
);

    localparam logic [9:0] NO_TILE    = 10'h3FF;
    localparam logic [7:0] FUSE_LOAD  = (FUSE_FRAMES  == 8'd0) ? 8'd1 : FUSE_FRAMES;
    localparam logic [7:0] BLAST_LOAD = (BLAST_FRAMES == 8'd0) ? 8'd1 : BLAST_FRAMES;

    typedef enum logic [2:0] {IDLE, ARMED, BLAST, CLEAR, REARM} state_t;

    state_t          state, state_n;
    logic [7:0]      fuse_cnt, fuse_n;
    logic [7:0]      blast_cnt, blast_n;
    logic [9:0]      col, col_n;
    logic [9:0]      row, row_n;
    logic [2:0]      slot, slot_n;
    logic [9:0]      snap_x, snap_y;
    logic [4:0][9:0] nb;

    logic            bomb_active_n, blast_active_n, ram_en_n;
    logic [9:0]      ram_addr_n;
    logic [4:0][9:0] die_n;

    function automatic logic blocked(input logic [9:0] c, input logic [9:0] r);
        return (c == 10'd0) || (c >= 10'd18) || (r == 10'd0) || (r >= 10'd14) ||
               (!c[0] && !r[0]);
    endfunction

    function automatic logic [9:0] tile_idx(input logic [9:0] c, input logic [9:0] r);
        logic [9:0] t;
        t = r * 10'd20 + c;
        return t;
    endfunction

    // Off-grid neighbours (col-1 / row-1 underflow to 1023, or beyond the
    // right/bottom edge) all land in the >=18 / >=14 blocked range.
    always_comb begin
        nb[0] = tile_idx(col, row);
        nb[1] = blocked(col - 10'd1, row) ? NO_TILE : tile_idx(col - 10'd1, row);
        nb[2] = blocked(col + 10'd1, row) ? NO_TILE : tile_idx(col + 10'd1, row);
        nb[3] = blocked(col, row - 10'd1) ? NO_TILE : tile_idx(col, row - 10'd1);
        nb[4] = blocked(col, row + 10'd1) ? NO_TILE : tile_idx(col, row + 10'd1);
    end

    assign snap_x = bus.userX + 10'd10;
    assign snap_y = bus.userY + 10'd13;

    always_comb begin
        state_n = state;
        fuse_n  = fuse_cnt;
        blast_n = blast_cnt;
        col_n   = col;
        row_n   = row;
        slot_n  = slot;
        case (state)
            IDLE: begin
                if (bus.bomb_drop) begin
                    col_n   = snap_x >> 5;
                    row_n   = snap_y >> 5;
                    fuse_n  = FUSE_LOAD;
                    slot_n  = 3'd0;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (bus.frame_tick) begin
                    if (fuse_cnt <= 8'd1) begin
                        fuse_n  = 8'd0;
                        blast_n = BLAST_LOAD;
                        state_n = BLAST;
                    end else begin
                        fuse_n = fuse_cnt - 8'd1;
                    end
                end
            end
            BLAST: begin
                if (bus.frame_tick) begin
                    if (blast_cnt <= 8'd1) begin
                        blast_n = 8'd0;
                        slot_n  = 3'd0;
                        state_n = CLEAR;
                    end else begin
                        blast_n = blast_cnt - 8'd1;
                    end
                end
            end
            CLEAR: begin
                if (slot == 3'd4) begin
                    slot_n  = 3'd0;
                    state_n = REARM;
                end else begin
                    slot_n = slot + 3'd1;
                end
            end
            REARM: begin
                if (!bus.bomb_drop) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from the next-state values and registered, so they
    // line up with the state they describe. col/row cannot change between
    // BLAST entry and the end of CLEAR, so nb doubles as the latched set.
    always_comb begin
        bomb_active_n  = (state_n == ARMED);
        blast_active_n = (state_n == BLAST);
        die_n          = (state_n == BLAST) ? nb : {5{NO_TILE}};
        ram_en_n       = 1'b0;
        ram_addr_n     = '0;
        if (state_n == CLEAR && slot_n <= 3'd4 && nb[slot_n] != NO_TILE) begin
            ram_en_n   = 1'b1;
            ram_addr_n = nb[slot_n];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            fuse_cnt         <= '0;
            blast_cnt        <= '0;
            col              <= '0;
            row              <= '0;
            slot             <= '0;
            bus.bombX        <= '0;
            bus.bombY        <= '0;
            bus.bomb_active  <= 1'b0;
            bus.blast_active <= 1'b0;
            bus.die_addr     <= {5{NO_TILE}};
            bus.ram_addr     <= '0;
            bus.ram_en       <= 1'b0;
        end else begin
            state            <= state_n;
            fuse_cnt         <= fuse_n;
            blast_cnt        <= blast_n;
            col              <= col_n;
            row              <= row_n;
            slot             <= slot_n;
            bus.bombX        <= col_n << 5;
            bus.bombY        <= row_n << 5;
            bus.bomb_active  <= bomb_active_n;
            bus.blast_active <= blast_active_n;
            bus.die_addr     <= die_n;
            bus.ram_addr     <= ram_addr_n;
            bus.ram_en       <= ram_en_n;
        end
    end

endmodule

// File: tb/tb_bomb_ctrl.sv
module tb_bomb_ctrl;

    localparam logic [9:0] NT = 10'h3FF;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    bomb_ctrl_if bus();

    bomb_ctrl #(
        .FUSE_FRAMES (8'd120),
        .BLAST_FRAMES(8'd30)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [9:0] ux, uy, bx, by;
        logic [9:0] die [5];
    } vec_t;

    vec_t vecs [6];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_full();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        step();
    endtask

    task automatic setv(input int i, input logic [9:0] ux, uy, bx, by,
                        input logic [9:0] d0, d1, d2, d3, d4);
        vecs[i].ux = ux; vecs[i].uy = uy; vecs[i].bx = bx; vecs[i].by = by;
        vecs[i].die[0] = d0; vecs[i].die[1] = d1; vecs[i].die[2] = d2;
        vecs[i].die[3] = d3; vecs[i].die[4] = d4;
    endtask

    // Full bomb cycle from IDLE; ends in the first REARM cycle.
    // A frame_tick coincides with the accepting edge and must not count.
    task automatic run_bomb(input int i, input logic hold);
        logic [9:0] ea;
        bus.userX = vecs[i].ux;
        bus.userY = vecs[i].uy;
        bus.bomb_drop  = 1'b1;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        bus.bomb_drop  = hold;
        chk($sformatf("v%0d accept bomb_active", i), bus.bomb_active, 1);
        chk($sformatf("v%0d bombX", i), bus.bombX, vecs[i].bx);
        chk($sformatf("v%0d bombY", i), bus.bombY, vecs[i].by);
        repeat (119) tick_full();
        chk($sformatf("v%0d tick119 bomb_active", i), bus.bomb_active, 1);
        chk($sformatf("v%0d tick119 blast_active", i), bus.blast_active, 0);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        chk($sformatf("v%0d tick120 blast_active", i), bus.blast_active, 1);
        chk($sformatf("v%0d tick120 bomb_active", i), bus.bomb_active, 0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("v%0d die_addr[%0d]", i, k), bus.die_addr[k], vecs[i].die[k]);
        repeat (29) tick_full();
        chk($sformatf("v%0d blast tick29 blast_active", i), bus.blast_active, 1);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        chk($sformatf("v%0d clear blast_active", i), bus.blast_active, 0);
        chk($sformatf("v%0d clear die_addr[0]", i), bus.die_addr[0], NT);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            ea = (vecs[i].die[k] != NT) ? vecs[i].die[k] : 10'd0;
            chk($sformatf("v%0d slot%0d ram_en", i, k), bus.ram_en, vecs[i].die[k] != NT);
            chk($sformatf("v%0d slot%0d ram_addr", i, k), bus.ram_addr, ea);
        end
        step();
        chk($sformatf("v%0d rearm ram_en", i), bus.ram_en, 0);
        chk($sformatf("v%0d rearm ram_addr", i), bus.ram_addr, 0);
        chk($sformatf("v%0d rearm bombX held", i), bus.bombX, vecs[i].bx);
    endtask

    logic seen_en;

    initial begin
        Reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.bomb_drop  = 1'b0;
        bus.userX = '0;
        bus.userY = '0;

        setv(0,   64,  32,  64,  32, 10'd22,  10'd21, 10'd23, NT,      NT);
        setv(1,   96,  96,  96,  96, 10'd63,  10'd62, 10'd64, 10'd43,  10'd83);
        setv(2,    0,   0,   0,   0, 10'd0,   NT,     NT,     NT,      NT);
        setv(3,  150, 200, 160, 192, 10'd125, NT,     NT,     10'd105, 10'd145);
        setv(4, 1020, 470,   0, 480, 10'd300, NT,     NT,     NT,      NT);
        setv(5,  600, 400, 608, 384, 10'd259, NT,     NT,     NT,      NT);

        repeat (3) step();
        chk("reset bomb_active", bus.bomb_active, 0);
        chk("reset blast_active", bus.blast_active, 0);
        chk("reset ram_en", bus.ram_en, 0);
        chk("reset ram_addr", bus.ram_addr, 0);
        chk("reset bombX", bus.bombX, 0);
        chk("reset bombY", bus.bombY, 0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("reset die_addr[%0d]", k), bus.die_addr[k], NT);
        Reset = 1'b0;
        step();
        chk("idle no drop", bus.bomb_active, 0);

        for (int i = 0; i < 6; i++) begin
            run_bomb(i, 1'b0);
            step();
        end

        // Held drop: one bomb, REARM holds until release, next rise re-arms.
        run_bomb(0, 1'b1);
        repeat (60) tick_full();
        chk("hold rearm bomb_active", bus.bomb_active, 0);
        chk("hold rearm blast_active", bus.blast_active, 0);
        bus.bomb_drop = 1'b0;
        step();
        step();
        chk("release idle bomb_active", bus.bomb_active, 0);
        bus.userX = 10'd96;
        bus.userY = 10'd96;
        bus.bomb_drop = 1'b1;
        step();
        bus.bomb_drop = 1'b0;
        chk("re-rise bomb_active", bus.bomb_active, 1);
        chk("re-rise bombX", bus.bombX, 96);

        // No ticks: ARMED holds indefinitely.
        repeat (300) step();
        chk("no tick bomb_active", bus.bomb_active, 1);
        chk("no tick blast_active", bus.blast_active, 0);
        repeat (120) tick_full();
        chk("after stall blast_active", bus.blast_active, 1);

        // Asynchronous reset in BLAST.
        Reset = 1'b1;
        #1;
        chk("async rst blast_active", bus.blast_active, 0);
        chk("async rst bomb_active", bus.bomb_active, 0);
        chk("async rst bombX", bus.bombX, 0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("async rst die_addr[%0d]", k), bus.die_addr[k], NT);
        step();
        Reset = 1'b0;
        seen_en = 1'b0;
        for (int c = 0; c < 80; c++) begin
            bus.frame_tick = c[0];
            step();
            if (bus.ram_en) seen_en = 1'b1;
        end
        bus.frame_tick = 1'b0;
        chk("no ram_en after reset", seen_en, 0);
        chk("post reset idle", bus.bomb_active, 0);

        // Drop held through reset release: accepted on the first edge.
        bus.userX = 10'd64;
        bus.userY = 10'd32;
        bus.bomb_drop = 1'b1;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        chk("drop at reset release bomb_active", bus.bomb_active, 1);
        chk("drop at reset release bombY", bus.bombY, 32);
        bus.bomb_drop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bomb_ctrl.md
BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 Parameter FUSE_FRAMES, default 8'd120: frame ticks from drop to detonation.
REQ-002 Parameter BLAST_FRAMES, default 8'd30: frame ticks the blast stays lethal.
REQ-003 Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 frame_tick  input  1  one-Clk-cycle pulse per video frame, synchronous to Clk.
REQ-006 bomb_drop  input  1  level request from the player controller.
REQ-007 userX, userY  input  10 each  player sprite top-left pixel position (sprite 20x27).
REQ-008 bombX, bombY  output  10 each  pixel top-left of the occupied bomb tile (tile col*32, row*32).
REQ-009 bomb_active  output  1  high in ARMED.
REQ-010 blast_active  output  1  high in BLAST.
REQ-011 die_addr  output  10 x 5 array  lethal tile indices: [0] centre, [1] left, [2] right, [3] up, [4] down.
REQ-012 ram_addr  output  10  map tile index to clear.
REQ-013 ram_en  output  1  map write strobe; the map writes 0 at ram_addr.

Function
REQ-014 Tile grid: 20 columns x 15 rows; index = row*20 + col; all index arithmetic 10-bit unsigned.
REQ-015 Sentinel 10'h3FF marks "no tile"; it never equals a valid index (max 299).
REQ-016 Drop snap: col = (userX+10)>>5, row = (userY+13)>>5, both captured in the cycle the drop is accepted.
REQ-017 Tile blocked when col==0, col>=18, row==0, row>=14, or (col even AND row even).
REQ-018 States: IDLE, ARMED, BLAST, CLEAR, REARM.
REQ-019 IDLE: if bomb_drop==1, capture col/row, load fuse counter with FUSE_FRAMES, enter ARMED next cycle.
REQ-020 ARMED: fuse counter decrements only on frame_tick; on the tick that brings it from 1 to 0, enter BLAST next cycle and load blast counter with BLAST_FRAMES.
REQ-021 FUSE_FRAMES==0 or BLAST_FRAMES==0: treated as 1.
REQ-022 BLAST: die_addr holds centre and the four one-tile neighbours; a neighbour that is blocked, or off-grid (col-1 underflow, row-1 underflow), is emitted as sentinel; centre is never sentinel.
REQ-023 BLAST: blast counter decrements on frame_tick; on reaching 0 enter CLEAR next cycle.
REQ-024 Outside BLAST, all five die_addr entries = 10'h3FF.
REQ-025 CLEAR: exactly 5 cycles, slot k=0..4 in order; ram_addr = die_addr value latched for slot k, ram_en=1 only if that value is not sentinel; ram_addr=0 when ram_en=0.
REQ-026 After slot 4, enter REARM; REARM returns to IDLE on the first cycle with bomb_drop==0.
REQ-027 bomb_drop is ignored outside IDLE; a held bomb_drop yields exactly one bomb per hold.
REQ-028 frame_tick coincident with a state transition is consumed only by the state being left; the counter of the entered state starts at its loaded value.
REQ-029 bombX/bombY hold the captured tile position from acceptance until the next acceptance.
REQ-030 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-031 Reset asserted at any time, including mid-ARMED, mid-BLAST or mid-CLEAR, immediately forces IDLE; counters = 0; bomb_active=0; blast_active=0; ram_en=0; ram_addr=0; bombX=bombY=0; die_addr all 10'h3FF.
REQ-032 After Reset deasserts with bomb_drop held high, a bomb is accepted on the first Clk edge.

Verification
REQ-033 userX=64, userY=32, bomb_drop pulse -> bombX=64, bombY=32; after 120 ticks, BLAST with die_addr = {22, 21, 23, 3FF, 3FF}.
REQ-034 userX=96, userY=96 (col 3, row 3) -> die_addr = {63, 62, 64, 43, 83}; CLEAR issues ram_en on 5 consecutive cycles with ram_addr 63, 62, 64, 43, 83.
REQ-035 Case REQ-033 in CLEAR -> ram_en high for exactly 3 cycles (22, 21, 23); low on slots 3 and 4.
REQ-036 bomb_drop held high for 400 frames -> exactly one bomb cycle; REARM persists until bomb_drop falls; the next rise starts a new bomb.
REQ-037 Reset pulsed during BLAST -> die_addr all 3FF and blast_active=0 before the next Clk edge; no ram_en follows.
REQ-038 frame_tick held low in ARMED -> the state holds indefinitely; bomb_active stays 1.
